sram_stream_fifo: RTL and testbench

SRAM_STREAM_FIFO -- requirements
Module: sram_stream_fifo

---
 rtl/sram_stream_fifo_pkg.sv | 15 +
 rtl/stream_skid_buf2.sv | 71 +++++++
 rtl/sram_stream_fifo.sv | 125 ++++++++++++
 tb/tb_sram_stream_fifo.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_fifo_pkg.sv
// Shared constants and types for the SRAM-backed stream FIFO.
package sram_stream_fifo_pkg;

  // Default geometry of the attached dual-port SRAM.
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_NUM_WMASKS = 2;

  // Depth of the registered output buffer that hides SRAM read latency.
  localparam int OBUF_DEPTH = 2;

  // Occupancy of the output buffer (0..OBUF_DEPTH).
  typedef logic [1:0] obuf_occ_t;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry FIFO that holds SRAM read data in front of the pop port.
module stream_skid_buf2
  import sram_stream_fifo_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output obuf_occ_t     o_occ
);

  logic [DW-1:0] r_ent0;
  logic [DW-1:0] r_ent1;
  logic          r_head;
  obuf_occ_t     r_occ;

  logic          w_tail;
  logic          w_wr;
  logic          w_rd;
  obuf_occ_t     w_occ_nxt;

  // Select the write slot and the next occupancy; a push into a full buffer
  // is only accepted when the head leaves in the same cycle.
  always_comb begin
    w_tail    = r_head ^ r_occ[0];
    w_rd      = i_pop & (r_occ != 2'd0);
    w_wr      = i_push & ((r_occ != 2'd2) | w_rd);
    w_occ_nxt = r_occ;
    case ({w_wr, w_rd})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Entry storage, head pointer and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0 <= {DW{1'b0}};
      r_ent1 <= {DW{1'b0}};
      r_head <= 1'b0;
      r_occ  <= 2'd0;
    end else if (flush) begin
      r_head <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_wr) begin
        if (w_tail) begin
          r_ent1 <= i_data;
        end else begin
          r_ent0 <= i_data;
        end
      end
      if (w_rd) begin
        r_head <= ~r_head;
      end
      r_occ <= w_occ_nxt;
    end
  end

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_head ? r_ent1 : r_ent0;
  assign o_occ   = r_occ;

endmodule

// File: rtl/sram_stream_fifo.sv
// Stream FIFO that stores words in an external dual-port SRAM (port 0 write,
// port 1 read, one-cycle read latency) and presents them through a
// two-entry output buffer so a word can be popped every cycle.
module sram_stream_fifo
  import sram_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  // SRAM word count at which no further write may be issued.
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_sram_cnt;
  logic                  r_inflight;
  logic                  r_run;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_unread;
  logic                  w_room;
  logic                  w_issue;
  logic                  w_capture;
  logic [2:0]            w_pending;
  logic [ADDR_WIDTH:0]   w_cnt_nxt;
  obuf_occ_t             w_occ;

  // Handshakes, read-issue decision and next SRAM word count.
  always_comb begin
    in_ready  = r_run & (r_sram_cnt < CNT_FULL) & ~flush;
    w_push    = in_valid & in_ready;
    w_pop     = out_valid & out_ready;
    // Words in the SRAM that have no read outstanding yet.
    w_unread  = (r_sram_cnt != {{ADDR_WIDTH{1'b0}}, r_inflight});
    // Buffer slots already promised after this cycle's pop.
    w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_room    = (w_pending < 3'd2);
    w_issue   = w_unread & w_room & ~flush;
    w_capture = r_inflight & ~flush;
    w_cnt_nxt = r_sram_cnt;
    case ({w_push, w_capture})
      2'b10:   w_cnt_nxt = r_sram_cnt + CNT_ONE;
      2'b01:   w_cnt_nxt = r_sram_cnt - CNT_ONE;
      default: w_cnt_nxt = r_sram_cnt;
    endcase
  end

  // Pointers, SRAM word count, in-flight read flag and the post-reset enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= {ADDR_WIDTH{1'b0}};
      r_rptr     <= {ADDR_WIDTH{1'b0}};
      r_sram_cnt <= {(ADDR_WIDTH+1){1'b0}};
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
    end else if (flush) begin
      r_wptr     <= {ADDR_WIDTH{1'b0}};
      r_rptr     <= {ADDR_WIDTH{1'b0}};
      r_sram_cnt <= {(ADDR_WIDTH+1){1'b0}};
      r_inflight <= 1'b0;
      r_run      <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_issue) begin
        r_rptr <= r_rptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      r_sram_cnt <= w_cnt_nxt;
      r_inflight <= w_issue;
      r_run      <= 1'b1;
    end
  end

  // Port 0 is only enabled in a push cycle; address and data follow the pointer.
  assign sram_csb0   = ~w_push;
  assign sram_web0   = ~w_push;
  assign sram_wmask0 = {NUM_WMASKS{1'b1}};
  assign sram_addr0  = r_wptr;
  assign sram_din0   = in_data;

  // Port 1 is only enabled in a read-issue cycle.
  assign sram_csb1   = ~w_issue;
  assign sram_addr1  = r_rptr;

  stream_skid_buf2 #(
    .DW(DATA_WIDTH)
  ) u_obuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .i_push  (w_capture),
    .i_data  (sram_dout1),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_occ   (w_occ)
  );

  assign count = {1'b0, r_sram_cnt} + {{ADDR_WIDTH{1'b0}}, w_occ};

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Self-checking bench for sram_stream_fifo with a behavioural dual-port SRAM.
module tb_sram_stream_fifo;

  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int NWM   = 2;
  localparam int DEPTH = 2048;
  localparam int FULLC = DEPTH + 2;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW+1:0] count;
  logic          sram_csb0;
  logic          sram_web0;
  logic [NWM-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int mdl_cnt = 0;
  logic [DW-1:0] sb_q[$];

  sram_stream_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NWM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: byte-masked synchronous write, one-cycle registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0) begin
      for (int b = 0; b < NWM; b++) begin
        if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  // Scoreboard: accepted pushes are queued, pops are compared in order and the
  // word count is checked against push/pop bookkeeping every cycle.
  always @(negedge clk) begin
    logic p_push;
    logic p_pop;
    logic [DW-1:0] exp_w;
    if (!rst_n) begin
      sb_q.delete();
      mdl_cnt = 0;
    end else begin
      total++;
      if (count !== (AW+2)'(mdl_cnt)) begin
        bad++;
        $display("FAIL count_model: got %0d want %0d at %0t", count, mdl_cnt, $time);
      end
      p_push = in_valid && in_ready;
      p_pop  = out_valid && out_ready;
      if (p_pop) begin
        pops++;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got %h want none at %0t", out_data, $time);
        end else begin
          exp_w = sb_q.pop_front();
          if (out_data !== exp_w) begin
            bad++;
            $display("FAIL pop_data: got %h want %h at %0t", out_data, exp_w, $time);
          end
        end
      end
      if (p_push) sb_q.push_back(in_data);
      if (flush) begin
        sb_q.delete();
        mdl_cnt = 0;
      end else begin
        mdl_cnt = mdl_cnt + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, sram_csb0, sram_web0, sram_csb1} !== 5'b00111) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00111", {out_valid, in_ready, sram_csb0, sram_web0, sram_csb1});
    end
    total++;
    if (count !== 13'd0 || out_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data: got count=%0d data=%h want 0/0000", count, out_data);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_edge: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single_word();
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    #1;
    total++;
    if ({sram_csb0, sram_web0} !== 2'b00 || sram_addr0 !== 11'd0 || sram_din0 !== 16'h1234 || sram_wmask0 !== 2'b11) begin
      bad++;
      $display("FAIL write_port: got csb/web=%b addr=%0d din=%h mask=%b want 00/0/1234/11",
               {sram_csb0, sram_web0}, sram_addr0, sram_din0, sram_wmask0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (sram_csb1 !== 1'b0 || sram_addr1 !== 11'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_issue: got csb1=%b addr1=%0d ov=%b want 0/0/0", sram_csb1, sram_addr1, out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_valid: got %b want 0", out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || count !== 13'd1) begin
      bad++;
      $display("FAIL single_out: got ov=%b data=%h cnt=%0d want 1/1234/1", out_valid, out_data, count);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || count !== 13'd0) begin
      bad++;
      $display("FAIL single_drain: got ov=%b cnt=%0d want 0/0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    int first_v = -1;
    int last_v  = -1;
    int p0      = pops;
    int not_rdy = 0;
    out_ready = 1'b1;
    for (int j = 0; j < 110; j++) begin
      if (j < 100) begin
        in_valid = 1'b1; in_data = 16'(j);
        if (!in_ready) not_rdy++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        if (first_v < 0) first_v = j;
        last_v = j;
      end
    end
    total++;
    if (not_rdy != 0) begin
      bad++;
      $display("FAIL stream_ready: got %0d stalls want 0", not_rdy);
    end
    total++;
    if (first_v != 2 || last_v != 101) begin
      bad++;
      $display("FAIL stream_window: got first=%0d last=%0d want 2/101", first_v, last_v);
    end
    total++;
    if (pops - p0 != 100) begin
      bad++;
      $display("FAIL stream_pops: got %0d want 100", pops - p0);
    end
  endtask

  task automatic fill_until_full(input int base, output int n);
    int guard = 0;
    n = 0;
    out_ready = 1'b0;
    while (in_ready && guard < 2200) begin
      in_valid = 1'b1; in_data = 16'(base + n);
      @(posedge clk); #1;
      n++; guard++;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int want);
    int guard = 0;
    int p0 = pops;
    out_ready = 1'b1;
    while (count != 13'd0 && guard < 2200) begin
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (count !== 13'd0 || pops - p0 != want) begin
      bad++;
      $display("FAIL drain: got cnt=%0d pops=%0d want 0/%0d", count, pops - p0, want);
    end
  endtask

  task automatic test_fill();
    int n;
    fill_until_full(16'h2000, n);
    total++;
    if (n != FULLC || count !== 13'(FULLC)) begin
      bad++;
      $display("FAIL fill_accept: got n=%0d cnt=%0d want %0d/%0d", n, count, FULLC, FULLC);
    end
    in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || sram_csb0 !== 1'b1) begin
      bad++;
      $display("FAIL full_block: got ready=%b csb0=%b want 0/1", in_ready, sram_csb0);
    end
    in_valid = 1'b0;
    drain(FULLC);
  endtask

  task automatic test_full_push_pop();
    int n;
    int over = 0;
    fill_until_full(16'h7000, n);
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1; in_data = 16'(16'hE000 + j);
      @(posedge clk); #1;
      if (count > 13'(FULLC)) over++;
    end
    in_valid = 1'b0;
    total++;
    if (over != 0) begin
      bad++;
      $display("FAIL full_overfill: got %0d cycles above limit want 0", over);
    end
    drain(int'(count));
  endtask

  task automatic test_flush();
    int guard = 0;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_data = 16'(16'h0050 + j);
      @(posedge clk); #1;
    end
    in_data = 16'hDEAD; flush = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      bad++;
      $display("FAIL flush_access: got ready=%b csb0=%b csb1=%b want 0/1/1", in_ready, sram_csb0, sram_csb1);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || count !== 13'd0) begin
      bad++;
      $display("FAIL flush_clear: got ov=%b cnt=%0d want 0/0", out_valid, count);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_discard: got ov=%b want 0", out_valid);
    end
    in_valid = 1'b1; in_data = 16'hBEEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL flush_next: got ov=%b data=%h want 1/beef", out_valid, out_data);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int p0;
    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in_valid = 1'b1; in_data = 16'(16'h3000 + j);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, sram_csb0, sram_web0, sram_csb1} !== 5'b00111 ||
        count !== 13'd0 || out_data !== 16'h0000) begin
      bad++;
      $display("FAIL midreset: got ctl=%b cnt=%0d data=%h want 00111/0/0000",
               {out_valid, in_ready, sram_csb0, sram_web0, sram_csb1}, count, out_data);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    p0 = pops;
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1; in_data = 16'(16'h4000 + j);
      if (j == 0) begin
        #1;
        total++;
        if (sram_addr0 !== 11'd0 || sram_csb0 !== 1'b0) begin
          bad++;
          $display("FAIL midreset_addr: got addr0=%0d csb0=%b want 0/0", sram_addr0, sram_csb0);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (pops - p0 != 10 || count !== 13'd0) begin
      bad++;
      $display("FAIL midreset_stream: got pops=%0d cnt=%0d want 10/0", pops - p0, count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fill();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d words want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
